// File: rtl/uart_tx_arbiter_if.sv
// Requester/uart_core side bundle of the TX arbiter: per-requester byte streams
// in, single byte stream out, plus the uart_core tx_done feedback.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   grant;
    logic [7:0]         tx_byte;
    logic               tx_valid;
    logic               tx_done;
    logic               busy;

    modport slave (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, grant, tx_byte, tx_valid, busy
    );

    modport master (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, grant, tx_byte, tx_valid, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that merges N byte streams into one uart_core TX port,
// pacing writes with a credit counter mirroring the core's TX FIFO space.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int TXFIFO_DEPTH = 5,
    parameter int MAX_LEN      = 16,
    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW   = $clog2(TXFIFO_DEPTH + 1),
    localparam int LW   = $clog2(MAX_LEN + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_arbiter_if.slave bus,
    output logic            o_dbg_state,
    output logic [CW-1:0]   o_dbg_credits,
    output logic [IDXW-1:0] o_dbg_rr_ptr
);
    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    localparam logic [CW-1:0] FULL = CW'(TXFIFO_DEPTH);

    state_t            r_state;
    logic [N_REQ-1:0]  r_grant;
    logic [IDXW-1:0]   r_gidx;
    logic [IDXW-1:0]   r_rr_ptr;
    logic [CW-1:0]     r_credits;
    logic [LW-1:0]     r_cnt;
    logic              r_tx_done_q;
    logic              r_tx_valid;
    logic [7:0]        r_tx_byte;

    logic [IDXW:0]     w_pick;
    logic [N_REQ-1:0]  w_ready;
    logic              w_accept;
    logic              w_done_rise;
    logic              w_last;
    logic [7:0]        w_data;

    // Returns {found, index} of the first valid requester at or after ptr, wrapping.
    function automatic logic [IDXW:0] f_pick(input logic [N_REQ-1:0] v,
                                             input logic [IDXW-1:0]  ptr);
        logic [IDXW:0] res;
        int            j;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (v[IDXW'(j)]) res = {1'b1, IDXW'(j)};
        end
        return res;
    endfunction

    // Handshake: a byte moves when req_valid[i] && req_ready[i] at a rising edge;
    // ready is only ever offered to the granted index, and only while credit remains.
    assign w_pick      = f_pick(bus.req_valid, r_rr_ptr);
    assign w_ready     = (r_state == XFER && r_credits != '0) ? r_grant : '0;
    assign w_accept    = |(bus.req_valid & w_ready);
    assign w_done_rise = bus.tx_done & ~r_tx_done_q;
    assign w_last      = bus.req_last[r_gidx] || (r_cnt == LW'(MAX_LEN - 1));

    always_comb begin
        w_data = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_gidx == IDXW'(i)) w_data = bus.req_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_gidx      <= '0;
            r_rr_ptr    <= '0;
            r_credits   <= FULL;
            r_cnt       <= '0;
            r_tx_done_q <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_tx_byte   <= 8'h00;
        end else begin
            r_tx_done_q <= bus.tx_done;
            r_tx_valid  <= w_accept;
            if (w_accept) r_tx_byte <= w_data;

            // Coincident accept and return cancel; returns beyond FULL are spurious.
            if (w_accept && !w_done_rise) begin
                r_credits <= r_credits - 1'b1;
            end else if (!w_accept && w_done_rise && r_credits != FULL) begin
                r_credits <= r_credits + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_pick[IDXW]) begin
                        r_state <= XFER;
                        r_gidx  <= w_pick[IDXW-1:0];
                        r_grant <= {{(N_REQ-1){1'b0}}, 1'b1} << w_pick[IDXW-1:0];
                        r_cnt   <= '0;
                    end
                end
                XFER: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state  <= IDLE;
                            r_grant  <= '0;
                            r_rr_ptr <= (r_gidx == IDXW'(N_REQ - 1)) ? '0 : r_gidx + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.grant      = r_grant;
    assign bus.tx_byte    = r_tx_byte;
    assign bus.tx_valid   = r_tx_valid;
    assign bus.busy       = (|r_grant) || (r_credits != FULL);

    assign o_dbg_state    = (r_state == XFER);
    assign o_dbg_credits  = r_credits;
    assign o_dbg_rr_ptr   = r_rr_ptr;
endmodule
